// File: rtl/ein_tx_seq.sv
// EIN transmit sequencer: paces one frame from header decode through modulation,
// then issues an ack (or a nak on abort/watchdog stall) and keeps frame statistics.
module ein_tx_seq #(
  parameter int TMR_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             header_done,
  input  logic [7:0]       header_eid,
  input  logic             is_fragment,
  input  logic             tx_active,
  input  logic             fifo_re,
  input  logic             abort,
  input  logic             goc_mode_req,
  input  logic [TMR_W-1:0] timeout_cycles,
  output logic             start_tx,
  output logic             header_done_clear,
  output logic             gen_ack,
  output logic             gen_nak,
  output logic [7:0]       ack_eid,
  output logic             goc_mode,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] nak_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_XMIT, S_DRAIN, S_ACK, S_NAK
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] wdog, wdog_nxt, wdog_inc;
  logic             frag_q, frag_nxt;
  logic             start_nxt, goc_nxt;
  logic [7:0]       eid_nxt;
  logic             timeout;

  // Saturating increment keeps a long stall from wrapping past the limit.
  assign wdog_inc = (&wdog) ? wdog : wdog + TMR_W'(1);
  assign timeout  = (timeout_cycles != '0) && (wdog == timeout_cycles);

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    frag_nxt  = frag_q;
    start_nxt = start_tx;
    goc_nxt   = goc_mode;
    eid_nxt   = ack_eid;
    case (state)
      S_IDLE: begin
        goc_nxt = goc_mode_req;
        if (header_done) begin
          eid_nxt   = header_eid;
          frag_nxt  = is_fragment;
          start_nxt = 1'b1;
          wdog_nxt  = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        wdog_nxt = wdog_inc;
        if (abort)          state_nxt = S_NAK;
        else if (tx_active) begin
          state_nxt = S_XMIT;
          wdog_nxt  = '0;
        end
        else if (timeout)   state_nxt = S_NAK;
      end
      S_XMIT: begin
        wdog_nxt = fifo_re ? '0 : wdog_inc;
        // Decoder drop beats both a same-cycle fifo_re and a timeout.
        if (abort)                   state_nxt = S_NAK;
        else if (!header_done)       state_nxt = S_DRAIN;
        else if (!fifo_re && timeout) state_nxt = S_NAK;
      end
      S_DRAIN: begin
        wdog_nxt = wdog_inc;
        if (abort) state_nxt = S_NAK;
        else if (!tx_active) begin
          start_nxt = 1'b0;
          state_nxt = frag_q ? S_IDLE : S_ACK;
        end
        else if (timeout) state_nxt = S_NAK;
      end
      S_ACK:   state_nxt = S_IDLE;
      S_NAK: begin
        start_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wdog        <= '0;
      frag_q      <= 1'b0;
      start_tx    <= 1'b0;
      goc_mode    <= 1'b0;
      ack_eid     <= '0;
      frame_count <= '0;
      nak_count   <= '0;
    end else begin
      state    <= state_nxt;
      wdog     <= wdog_nxt;
      frag_q   <= frag_nxt;
      start_tx <= start_nxt;
      goc_mode <= goc_nxt;
      ack_eid  <= eid_nxt;
      if (state == S_ACK) frame_count <= frame_count + CNT_W'(1);
      if (state == S_NAK) nak_count   <= nak_count + CNT_W'(1);
    end
  end

  // Pulses decode straight from the registered one-cycle ACK/NAK states.
  assign gen_ack           = (state == S_ACK);
  assign gen_nak           = (state == S_NAK);
  assign header_done_clear = (state == S_NAK);
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_ein_tx_seq.sv
// Directed bench for ein_tx_seq: normal/fragment frames, watchdog stall, abort,
// tie-break rules, goc_mode hold and mid-frame reset.
module tb_ein_tx_seq;
  localparam int TMR_W = 24;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, header_done, is_fragment, tx_active, fifo_re, abort, goc_mode_req;
  logic [7:0]       header_eid;
  logic [TMR_W-1:0] timeout_cycles;
  logic             start_tx, header_done_clear, gen_ack, gen_nak, goc_mode, busy;
  logic [7:0]       ack_eid;
  logic [CNT_W-1:0] frame_count, nak_count;

  int n_cmp = 0, n_err = 0;
  int acks = 0, naks = 0, both = 0;
  int acks_b, naks_b;

  ein_tx_seq #(.TMR_W(TMR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .header_done(header_done), .header_eid(header_eid),
    .is_fragment(is_fragment), .tx_active(tx_active), .fifo_re(fifo_re), .abort(abort),
    .goc_mode_req(goc_mode_req), .timeout_cycles(timeout_cycles), .start_tx(start_tx),
    .header_done_clear(header_done_clear), .gen_ack(gen_ack), .gen_nak(gen_nak),
    .ack_eid(ack_eid), .goc_mode(goc_mode), .busy(busy), .frame_count(frame_count),
    .nak_count(nak_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset) begin
    if (gen_ack) acks++;
    if (gen_nak) naks++;
    if (gen_ack && gen_nak) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; header_done = 1'b0; is_fragment = 1'b0; tx_active = 1'b0;
    fifo_re = 1'b0; abort = 1'b0; goc_mode_req = 1'b0; header_eid = 8'h00;
    timeout_cycles = '0;
    tick(); tick();
    chk("rst_start_tx", start_tx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack_eid", ack_eid, 0);
    chk("rst_pulses", {gen_ack, gen_nak, header_done_clear}, 0);
    chk("rst_counts", {frame_count, nak_count}, 0);
    reset = 1'b0;

    // normal frame
    timeout_cycles = 100; header_eid = 8'h5A; header_done = 1'b1;
    tick();
    chk("nf_start_tx", start_tx, 1);
    chk("nf_busy", busy, 1);
    chk("nf_eid_latch", ack_eid, 8'h5A);
    tx_active = 1'b1;
    tick();
    for (int i = 1; i <= 40; i++) begin
      fifo_re = (i % 10 == 0);
      tick();
    end
    fifo_re = 1'b0;
    chk("nf_no_nak", naks, 0);
    header_eid = 8'h11; header_done = 1'b0;
    tick();
    chk("nf_eid_hold", ack_eid, 8'h5A);
    chk("nf_drain_start_tx", start_tx, 1);
    tx_active = 1'b0;
    tick();
    chk("nf_gen_ack", gen_ack, 1);
    chk("nf_start_tx_fall", start_tx, 0);
    tick();
    chk("nf_frame_count", frame_count, 1);
    chk("nf_idle", busy, 0);
    chk("nf_one_ack", acks, 1);

    // fragment frame
    is_fragment = 1'b1; header_done = 1'b1;
    tick(); tx_active = 1'b1;
    tick(); tick(); tick(); tick();
    header_done = 1'b0;
    tick();
    chk("fr_drain_start_tx", start_tx, 1);
    tx_active = 1'b0;
    tick();
    chk("fr_idle", busy, 0);
    chk("fr_start_tx", start_tx, 0);
    chk("fr_frame_count", frame_count, 1);
    chk("fr_no_ack", acks, 1);
    is_fragment = 1'b0;

    // watchdog stall, limit 20
    timeout_cycles = 20; header_done = 1'b1;
    tick(); tx_active = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) tick();
    chk("st_no_early_nak", naks, 0);
    chk("st_busy_c20", busy, 1);
    tick();
    chk("st_gen_nak_c21", gen_nak, 1);
    chk("st_hdr_clear", header_done_clear, 1);
    header_done = 1'b0; tx_active = 1'b0;
    tick();
    chk("st_nak_count", nak_count, 1);
    chk("st_start_tx", start_tx, 0);
    chk("st_idle", busy, 0);

    // watchdog disabled, long stall, then abort
    timeout_cycles = 0; header_done = 1'b1;
    tick(); tx_active = 1'b1;
    tick();
    repeat (5000) tick();
    chk("wd0_no_nak", naks, 1);
    chk("wd0_busy", busy, 1);
    abort = 1'b1;
    tick();
    chk("wd0_abort_nak", gen_nak, 1);
    abort = 1'b0; header_done = 1'b0; tx_active = 1'b0;
    tick();
    chk("wd0_nak_count", nak_count, 2);

    // fifo_re ties with timeout; back-to-back frame; abort in START
    timeout_cycles = 5; header_done = 1'b1;
    tick(); tx_active = 1'b1;
    tick();
    repeat (5) tick();
    fifo_re = 1'b1;
    tick();
    chk("tie_fifo_wins", gen_nak, 0);
    chk("tie_busy", busy, 1);
    fifo_re = 1'b0; header_done = 1'b0;
    tick();
    tx_active = 1'b0; header_done = 1'b1;
    tick();
    chk("b2b_gen_ack", gen_ack, 1);
    tick();
    chk("b2b_idle_gap", busy, 0);
    chk("b2b_frame_count", frame_count, 2);
    tick();
    chk("b2b_restart", {busy, start_tx}, 2'b11);
    abort = 1'b1;
    tick();
    chk("ab_start_nak", gen_nak, 1);
    abort = 1'b0; header_done = 1'b0;
    tick();
    chk("ab_nak_count", nak_count, 3);
    abort = 1'b1;
    tick();
    chk("ab_idle_ignored", {busy, nak_count}, 3);
    abort = 1'b0;

    // goc_mode held outside IDLE
    goc_mode_req = 1'b1;
    tick();
    chk("goc_idle_follow", goc_mode, 1);
    timeout_cycles = 0; is_fragment = 1'b1; header_done = 1'b1;
    tick(); goc_mode_req = 1'b0; tx_active = 1'b1;
    tick(); tick(); tick();
    chk("goc_xmit_hold", goc_mode, 1);
    header_done = 1'b0;
    tick(); tx_active = 1'b0;
    tick();
    chk("goc_first_idle", goc_mode, 1);
    tick();
    chk("goc_update", goc_mode, 0);

    // reset during XMIT
    goc_mode_req = 1'b1; is_fragment = 1'b0;
    tick();
    header_eid = 8'h33; header_done = 1'b1;
    tick(); tx_active = 1'b1;
    tick(); tick();
    acks_b = acks; naks_b = naks;
    reset = 1'b1;
    tick();
    chk("mr_start_tx", start_tx, 0);
    chk("mr_busy", busy, 0);
    chk("mr_eid_goc", {ack_eid, goc_mode}, 0);
    chk("mr_counts", {frame_count, nak_count}, 0);
    chk("mr_pulses", {gen_ack, gen_nak, header_done_clear}, 0);
    reset = 1'b0; header_done = 1'b0; tx_active = 1'b0; goc_mode_req = 1'b0;
    tick(); tick();
    chk("mr_no_pulse", (acks - acks_b) + (naks - naks_b), 0);
    chk("ack_nak_excl", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ein_tx_seq.md
EIN_TX_SEQ -- requirements
Module: ein_tx_seq

Interface
REQ-001 SHALL have parameter TMR_W, default 24, width of the progress watchdog counter and timeout_cycles.
REQ-002 SHALL have parameter CNT_W, default 16, width of frame_count and nak_count.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 header_done  in  1  level from the header decoder: a frame header has been parsed and payload is queued.
REQ-006 header_eid  in  8  event ID of the current frame, valid while header_done=1.
REQ-007 is_fragment  in  1  current frame is a fragment, valid while header_done=1.
REQ-008 tx_active  in  1  modulator is shifting bits onto EMO/EDI/ECI.
REQ-009 fifo_re  in  1  one-cycle strobe: modulator consumed one payload byte.
REQ-010 abort  in  1  host request to kill the current frame.
REQ-011 goc_mode_req  in  1  requested GOC/EIN modulation mode.
REQ-012 timeout_cycles  in  TMR_W  watchdog limit in clk cycles; 0 disables the watchdog.
REQ-013 start_tx  out  1  level to the modulator: transmission enabled.
REQ-014 header_done_clear  out  1  one-cycle pulse that discards the current frame in the header decoder.
REQ-015 gen_ack, gen_nak  out  1 each  one-cycle pulses to the ack generator.
REQ-016 ack_eid  out  8  EID latched at frame start, held stable until the next frame start.
REQ-017 goc_mode  out  1  mode applied to the modulator.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frame_count, nak_count  out  CNT_W each  completed-frame and failed-frame counters.

Function
REQ-020 States SHALL be IDLE, START, XMIT, DRAIN, ACK and NAK, all registered.
REQ-021 IDLE: goc_mode<=goc_mode_req every cycle; goc_mode SHALL NOT change in any other state.
REQ-022 IDLE with header_done=1: ack_eid<=header_eid, frag_q<=is_fragment, start_tx<=1, watchdog<=0, go START.
REQ-023 START: tx_active=1 -> XMIT with watchdog<=0.
REQ-024 XMIT: watchdog<=0 on fifo_re, else watchdog+1; header_done=0 -> DRAIN.
REQ-025 DRAIN: tx_active=0 -> start_tx<=0; frag_q=1 -> IDLE; frag_q=0 -> ACK.
REQ-026 ACK (one cycle): gen_ack=1, frame_count+1, go IDLE.
REQ-027 NAK (one cycle): gen_nak=1, header_done_clear=1, start_tx<=0, nak_count+1, go IDLE.
REQ-028 Watchdog SHALL count in START, XMIT and DRAIN; at watchdog==timeout_cycles (timeout_cycles!=0) -> NAK.
REQ-029 Watchdog SHALL saturate at all-ones; it SHALL NOT wrap.
REQ-030 abort=1 in START, XMIT or DRAIN -> NAK next cycle, priority over every other transition; abort in IDLE, ACK or NAK SHALL be ignored.
REQ-031 fifo_re and timeout in the same XMIT cycle: fifo_re wins, no NAK.
REQ-032 header_done=0 and timeout in the same XMIT cycle: DRAIN wins.
REQ-033 Counters SHALL wrap modulo 2^CNT_W.
REQ-034 header_done still 1 on return to IDLE SHALL start the next frame after one IDLE cycle.
REQ-035 gen_ack and gen_nak SHALL never be high in the same cycle.

Reset
REQ-036 reset SHALL force state=IDLE, start_tx=0, header_done_clear=0, gen_ack=0, gen_nak=0, ack_eid=0, goc_mode=0, busy=0, watchdog=0, frame_count=0, nak_count=0.
REQ-037 reset mid-frame SHALL drop start_tx the next cycle and SHALL emit no ack or nak pulse.

Verification
REQ-038 Normal frame: header_eid=0x5A, is_fragment=0, timeout=100, fifo_re every 10 cycles, header_done falls, tx_active falls -> exactly one gen_ack, ack_eid=0x5A, frame_count=1.
REQ-039 Fragment frame: same stimulus with is_fragment=1 -> no gen_ack, start_tx falls, return to IDLE, frame_count=0.
REQ-040 Stall: timeout_cycles=20, no fifo_re after tx_active rises -> gen_nak and header_done_clear on cycle 21 after XMIT entry, nak_count=1.
REQ-041 timeout_cycles=0, 5000-cycle stall -> no NAK; abort -> NAK next cycle.
REQ-042 goc_mode_req toggles during XMIT -> goc_mode unchanged until IDLE, then updates one cycle later.
REQ-043 reset asserted during XMIT -> all outputs at reset values next cycle; no pulses.
